// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: LANES InvSbox lanes reused over 16/LANES cycles on a rotating work register.
// Define INV_SUB_BYTES_SELFCHECK_EN to add a forward-Sbox round-trip check per lane (sticky chk_err).

module inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [2047:0] TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  // Entry a sits at bits [2047-8a -: 8].
  assign y_o = TAB[{~a_i, 3'b111} -: 8];
endmodule

`ifdef INV_SUB_BYTES_SELFCHECK_EN
module fwd_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [2047:0] TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y_o = TAB[{~a_i, 3'b111} -: 8];
endmodule
`endif

module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] message,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] Dmessage,
  output logic         busy,
  output logic         chk_err
);
  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = 8 * LANES;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  work_q, work_d, rot;
  logic [LW-1:0] subst;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];
  logic          rdy;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = work_q[127-8*l -: 8];
    inv_sbox u_inv (.a_i(lane_in[l]), .y_o(lane_out[l]));
  end

  always_comb begin
    subst = '0;
    for (int l = 0; l < LANES; l++) subst[LW-1-8*l -: 8] = lane_out[l];
  end

  // Substituted bytes re-enter at the bottom; after N beats the order is restored.
  if (LANES == 16) begin : g_full
    assign rot = subst;
  end else begin : g_part
    assign rot = {work_q[127-LW:0], subst};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    rdy     = 1'b0;
    case (state_q)
      IDLE: rdy = 1'b1;
      RUN: begin
        work_d = rot;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        rdy = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (in_valid && rdy) begin
      work_d  = message;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = rdy;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign Dmessage  = work_q;

`ifdef INV_SUB_BYTES_SELFCHECK_EN
  logic [7:0]       fwd [LANES];
  logic [LANES-1:0] mism;
  logic             chk_q;

  for (genvar l = 0; l < LANES; l++) begin : g_chk
    fwd_sbox u_fwd (.a_i(lane_out[l]), .y_o(fwd[l]));
  end

  always_comb begin
    mism = '0;
    for (int l = 0; l < LANES; l++) mism[l] = (fwd[l] != lane_in[l]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        chk_q <= 1'b0;
    else if (state_q == RUN && |mism)  chk_q <= 1'b1;
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: four instances (LANES 1/2/4/16) against a GF(2^8)-derived InvSbox model.
module tb_inv_sub_bytes_iter;
  localparam int ND = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv [ND], ir [ND], ov [ND], ordy [ND], bz [ND], ce [ND];
  logic [127:0] mi [ND], dm [ND];
  logic [7:0]   inv_tab [256];
  int           n_checks = 0, n_err = 0;

  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.LANES(1)) u_l1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .message(mi[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .Dmessage(dm[0]), .busy(bz[0]), .chk_err(ce[0]));
  inv_sub_bytes_iter #(.LANES(2)) u_l2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .message(mi[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .Dmessage(dm[1]), .busy(bz[1]), .chk_err(ce[1]));
  inv_sub_bytes_iter #(.LANES(4)) u_l4 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .message(mi[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .Dmessage(dm[2]), .busy(bz[2]), .chk_err(ce[2]));
  inv_sub_bytes_iter #(.LANES(16)) u_l16 (.clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .message(mi[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .Dmessage(dm[3]), .busy(bz[3]), .chk_err(ce[3]));

  function automatic int lat_of(input int d);
    case (d)
      0: return 16;
      1: return 8;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from first principles: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_math(input logic [7:0] x);
    logic [7:0] b, r;
    b = 8'h01;
    for (int i = 0; i < 254; i++) b = gmul(b, x);
    if (x == 8'h00) b = 8'h00;
    r = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] m);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tab[m[127-8*i -: 8]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; returns with the result presented (out_valid high).
  task automatic do_op(input int d, input logic [127:0] msg, input string tag);
    int cyc;
    cyc = 0;
    while (!ir[d] && cyc < 50) begin @(negedge clk); cyc++; end
    check1($sformatf("%s_d%0d_ready", tag, d), ir[d], 1'b1);
    iv[d] = 1'b1;
    mi[d] = msg;
    @(negedge clk);
    iv[d] = 1'b0;
    check1($sformatf("%s_d%0d_busy", tag, d), bz[d], 1'b1);
    cyc = 0;
    while (!ov[d] && cyc < 40) begin @(negedge clk); cyc++; end
    check($sformatf("%s_d%0d_latency", tag, d), 128'(cyc), 128'(lat_of(d)));
    check($sformatf("%s_d%0d_data", tag, d), dm[d], model(msg));
    check1($sformatf("%s_d%0d_chk_err", tag, d), ce[d], 1'b0);
  endtask

  initial begin
    logic [127:0] snap, m;
    int cyc;

    for (int x = 0; x < 256; x++) inv_tab[sbox_math(8'(x))] = 8'(x);

    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; mi[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check1($sformatf("rst_d%0d_out_valid", d), ov[d], 1'b0);
      check1($sformatf("rst_d%0d_busy", d), bz[d], 1'b0);
      check1($sformatf("rst_d%0d_in_ready", d), ir[d], 1'b1);
      check1($sformatf("rst_d%0d_chk_err", d), ce[d], 1'b0);
      check($sformatf("rst_d%0d_dmessage", d), dm[d], 128'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // All lane widths on the 0x63 pattern: latency 16/8/4/1, result all zero.
    for (int d = 0; d < ND; d++) begin
      do_op(d, {16{8'h63}}, "p63");
      check($sformatf("p63_d%0d_const", d), dm[d], 128'h0);
      @(negedge clk);
    end

    // Back-to-back directed vectors on LANES=4 (second and third accepted straight from DONE).
    do_op(2, {16{8'h7C}}, "p7c");
    check("p7c_const", dm[2], {16{8'h01}});
    do_op(2, {16{8'h00}}, "p00");
    check("p00_const", dm[2], {16{8'h52}});
    do_op(2, 128'hED16_5263_0000_0000_0000_0000_0000_0000, "pmix");
    check("pmix_const", dm[2], 128'h53FF_4800_5252_5252_5252_5252_5252_5252);
    @(negedge clk);

    // Stall in DONE for 10 cycles.
    ordy[2] = 1'b0;
    do_op(2, {$urandom, $urandom, $urandom, $urandom}, "stall");
    snap = dm[2];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check1($sformatf("stall_valid_%0d", i), ov[2], 1'b1);
      check($sformatf("stall_data_%0d", i), dm[2], snap);
      check1($sformatf("stall_in_ready_%0d", i), ir[2], 1'b0);
    end

    // Release with a new request in the same cycle: accepted with no idle bubble.
    m = {$urandom, $urandom, $urandom, $urandom};
    ordy[2] = 1'b1;
    iv[2] = 1'b1;
    mi[2] = m;
    #1;
    check1("release_in_ready", ir[2], 1'b1);
    @(negedge clk);
    iv[2] = 1'b0;
    check1("release_busy", bz[2], 1'b1);
    check1("release_out_valid", ov[2], 1'b0);
    cyc = 0;
    while (!ov[2] && cyc < 40) begin @(negedge clk); cyc++; end
    check("release_latency", 128'(cyc), 128'd4);
    check("release_data", dm[2], model(m));
    @(negedge clk);

    // Reset during RUN beat 2 on LANES=4, then a clean operation.
    iv[2] = 1'b1;
    mi[2] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    iv[2] = 1'b0;
    repeat (2) @(negedge clk);
    check1("pre_rst_busy", bz[2], 1'b1);
    rst_n = 1'b0;
    #1;
    check1("midrst_out_valid", ov[2], 1'b0);
    check1("midrst_busy", bz[2], 1'b0);
    check1("midrst_in_ready", ir[2], 1'b1);
    check("midrst_dmessage", dm[2], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(2, {$urandom, $urandom, $urandom, $urandom}, "postrst");
    @(negedge clk);

    // Random traffic with occasional consumer stalls on every lane width.
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 5; k++) begin
        do_op(d, {$urandom, $urandom, $urandom, $urandom}, $sformatf("rnd%0d", k));
        if ($urandom_range(0, 1) == 1) begin
          snap = dm[d];
          ordy[d] = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          check1($sformatf("rnd%0d_d%0d_hold_valid", k, d), ov[d], 1'b1);
          check($sformatf("rnd%0d_d%0d_hold_data", k, d), dm[d], snap);
          ordy[d] = 1'b1;
        end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
